// File: rtl/module_divider_if.sv
// Request/result bundle between the register-file read/write ports and the divider.
// Latency: n/a (wiring only).
// Backpressure: none; requesters watch busy_o, the divider ignores start_i while busy.
interface module_divider_if;
  logic        start_i;
  logic        kill_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic        we_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;

  // Requester side: issues operations, consumes the write-port strobe.
  modport master (
    output start_i, kill_i, op_i, a_i, b_i, rd_i,
    input  busy_o, done_o, we_o, rd_o, result_o
  );

  // Divider side.
  modport slave (
    input  start_i, kill_i, op_i, a_i, b_i, rd_i,
    output busy_o, done_o, we_o, rd_o, result_o
  );
endinterface

// File: rtl/module_divider.sv
// RV32M DIV/DIVU/REM/REMU unit, restoring division at one quotient bit per cycle.
// Latency: fixed 33 cycles from the start edge to the done/we pulse; one op per 34 cycles.
// Backpressure: start_i is only taken in IDLE; while busy_o=1 requests are dropped, not queued.
module module_divider (
  input logic              clk_i,
  input logic              rst_i,
  module_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // op_i encoding: bit 1 selects remainder, bit 0 selects unsigned.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  state_t      state;
  state_t      state_nxt;

  // Operation context captured at start.
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        a_neg;       // dividend was negative (signed ops only)
  logic        b_neg;       // divisor was negative (signed ops only)
  logic        div_zero;    // divisor was zero

  // Division datapath. dvd shifts left each step; the freed LSB collects the
  // quotient bit, so after 32 steps dvd holds the quotient magnitude.
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  cnt;

  logic        done;
  logic [4:0]  rd_out;
  logic [31:0] result;

  // Start-time operand conditioning.
  logic        is_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // One restoring step.
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_step;

  // Final result selection.
  logic        is_rem;
  logic        is_signed_q;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_sel;

  // Magnitudes for signed ops; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude 2^31.
  always_comb begin
    is_signed_in = (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    a_neg_in     = is_signed_in && bus.a_i[31];
    b_neg_in     = is_signed_in && bus.b_i[31];
    a_mag        = a_neg_in ? (~bus.a_i + 32'd1) : bus.a_i;
    b_mag        = b_neg_in ? (~bus.b_i + 32'd1) : bus.b_i;
  end

  // Shift in the next dividend bit and trial-subtract with a 33-bit compare.
  always_comb begin
    rem_sh   = {rem, dvd[31]};
    diff     = rem_sh - {1'b0, dvs};
    take     = ~diff[32];
    rem_step = take ? diff[31:0] : rem_sh[31:0];
  end

  // Sign correction and special cases. Overflow (-2^31 / -1) needs no special
  // handling: the magnitude quotient 2^31 negates to 0x80000000 and the
  // remainder is 0. A zero divisor leaves rem = |a|, so sign restore gives a_i
  // back for REM/REMU; only the DIV quotient needs forcing to all ones.
  always_comb begin
    is_rem      = op_q[1];
    is_signed_q = ~op_q[0];
    quo_fix     = (is_signed_q && (a_neg ^ b_neg)) ? (~dvd + 32'd1) : dvd;
    rem_fix     = (is_signed_q && a_neg) ? (~rem + 32'd1) : rem;
    res_sel     = quo_fix;
    if (is_rem) begin
      res_sel = rem_fix;
    end else if (div_zero) begin
      res_sel = 32'hFFFF_FFFF;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; kill aborts anything in flight and beats start in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start_i && !bus.kill_i) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (bus.kill_i) begin
          state_nxt = IDLE;
        end else if (cnt == 5'd31) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, iteration and registered result/strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= OP_DIV;
      rd_q     <= 5'd0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      dvd      <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 32'd0;
      cnt      <= 5'd0;
      done     <= 1'b0;
      rd_out   <= 5'd0;
      result   <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.kill_i) begin
            op_q     <= bus.op_i;
            rd_q     <= bus.rd_i;
            a_neg    <= a_neg_in;
            b_neg    <= b_neg_in;
            div_zero <= (bus.b_i == 32'd0);
            dvd      <= a_mag;
            dvs      <= b_mag;
            rem      <= 32'd0;
            cnt      <= 5'd0;
          end
        end
        CALC: begin
          if (!bus.kill_i) begin
            rem <= rem_step;
            dvd <= {dvd[30:0], take};
            cnt <= cnt + 5'd1;
          end
        end
        FIX: begin
          // A kill here drops the result; previous result/rd stay visible.
          if (!bus.kill_i) begin
            result <= res_sel;
            rd_out <= rd_q;
            done   <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o   = (state != IDLE);
  assign bus.done_o   = done;
  assign bus.we_o     = done;
  assign bus.rd_o     = rd_out;
  assign bus.result_o = result;

endmodule
